// File: rtl/clk_reset_gen.sv
// Clock/reset stage: selectable divider, synchronised reset release
// and a ready flag ahead of the processor wrapper.
// Ports: clock/reset in; div_req/div_sel request a new ratio;
// imem/dmem/processor/regfile clocks, proc_reset, ready, div_ack,
// proc_edge and cur_sel out.
module clk_reset_gen #(
  parameter logic [1:0] DIV_SEL_RST = 2'd1,
  parameter int         RST_HOLD    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       div_req,
  input  logic [1:0] div_sel,
  output logic       imem_clock,
  output logic       dmem_clock,
  output logic       processor_clock,
  output logic       regfile_clock,
  output logic       proc_reset,
  output logic       ready,
  output logic       div_ack,
  output logic       proc_edge,
  output logic [1:0] cur_sel
);

  typedef enum logic [1:0] {
    SYNC,
    HOLD,
    RUN
  } state_t;

  localparam int HW =
    (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

  state_t        state;
  logic [1:0]    sync;
  logic [3:0]    cnt;
  logic [3:0]    cnt_next;
  logic [3:0]    last;
  logic [3:0]    half;
  logic [4:0]    n_full;
  logic          slow_q;
  logic          wrap;
  logic [HW-1:0] hold_cnt;

  assign imem_clock      = clock;
  assign dmem_clock      = ~clock;
  assign processor_clock = ~slow_q;
  assign regfile_clock   = ~slow_q;

  always_comb begin
    n_full   = 5'd2 << cur_sel;
    last     = 4'(n_full - 5'd1);
    half     = n_full[4:1];
    wrap     = (state != SYNC) && (cnt == last);
    cnt_next = cnt + 4'd1;
    if (state == SYNC || wrap)
      cnt_next = 4'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      sync       <= 2'b00;
      cnt        <= 4'd0;
      slow_q     <= 1'b0;
      cur_sel    <= DIV_SEL_RST;
      proc_reset <= 1'b1;
      ready      <= 1'b0;
      div_ack    <= 1'b0;
      proc_edge  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      sync      <= {sync[0], 1'b1};
      cnt       <= cnt_next;
      // a wrap always lands on cnt 0, so the
      // select swap never shortens a phase
      slow_q    <= (cnt_next >= half);
      proc_edge <= wrap;
      div_ack   <= 1'b0;
      unique case (state)
        SYNC: begin
          if (sync == 2'b01)
            state <= HOLD;
        end
        HOLD: begin
          if (wrap && hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 1'b1;
          // leave on a processor falling edge
          if (hold_cnt == HOLD_MAX &&
              cnt_next == half) begin
            state      <= RUN;
            proc_reset <= 1'b0;
            ready      <= 1'b1;
          end
        end
        RUN: begin
          if (wrap && div_req) begin
            cur_sel <= div_sel;
            div_ack <= 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
